// File: rtl/digit_window_ctrl.sv
// digit_window_ctrl: tracks the active-video raster, requests glyph ROM pixels for a scaled
// GW x GH window at (X0,Y0) and emits 2-clk aligned RGB565 + de/hs/vs. Option: DIGIT_WIN_BORDER_EN.
module digit_window_ctrl #(
  parameter int          X0       = 200,
  parameter int          Y0       = 100,
  parameter int          GW       = 64,
  parameter int          GH       = 128,
  parameter int          SCALE    = 2,
  parameter logic        SYNC_POL = 1'b0,
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h001F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [12:0] addr,
  input  logic        num,
  output logic [15:0] rgb,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out
);

  localparam int          SH        = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
  localparam int          GXW       = $clog2(GW);
  localparam int          GYW       = $clog2(GH);
  localparam logic [10:0] X_LO      = 11'(X0);
  localparam logic [10:0] X_HI      = 11'(X0 + GW * SCALE - 1);
  localparam logic [10:0] Y_LO      = 11'(Y0);
  localparam logic [10:0] Y_HI      = 11'(Y0 + GH * SCALE - 1);
  localparam logic [10:0] CNT_MAX   = 11'h7FF;
  localparam logic        SYNC_IDLE = ~SYNC_POL;

  logic [10:0]    r_hCnt;
  logic [10:0]    r_vCnt;
  logic [12:0]    r_addr;
  logic           r_inWinD1;
  logic           r_deD1;
  logic           r_hsD1;
  logic           r_vsD1;
  logic [15:0]    r_rgb;
  logic           r_deOut;
  logic           r_hsOut;
  logic           r_vsOut;

  logic           w_deFall;
  logic           w_vsActive;
  logic           w_inWin;
  logic [10:0]    w_dx;
  logic [10:0]    w_dy;
  logic [GXW-1:0] w_gx;
  logic [GYW-1:0] w_gy;
  logic [12:0]    w_addrNext;
  logic [15:0]    w_rgbNext;

  // r_deD1 doubles as the previous-cycle de used for end-of-line detection
  assign w_deFall   = r_deD1 & ~de_in;
  assign w_vsActive = (vs_in == SYNC_POL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hCnt <= '0;
    end else if (de_in) begin
      if (r_hCnt != CNT_MAX) r_hCnt <= r_hCnt + 11'd1;
    end else if (r_deD1) begin
      r_hCnt <= '0;
    end
  end

  // vsync has priority so a vsync arriving mid-line restarts the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vCnt <= '0;
    end else if (w_vsActive) begin
      r_vCnt <= '0;
    end else if (w_deFall && (r_vCnt != CNT_MAX)) begin
      r_vCnt <= r_vCnt + 11'd1;
    end
  end

  always_comb begin
    w_inWin    = de_in && (r_hCnt >= X_LO) && (r_hCnt <= X_HI)
                       && (r_vCnt >= Y_LO) && (r_vCnt <= Y_HI);
    w_dx       = r_hCnt - X_LO;
    w_dy       = r_vCnt - Y_LO;
    w_gx       = GXW'(w_dx >> SH);
    w_gy       = GYW'(w_dy >> SH);
    w_addrNext = w_inWin ? 13'({w_gy, w_gx}) : 13'd0;
  end

`ifdef DIGIT_WIN_BORDER_EN
  localparam logic [10:0] BX_LO = 11'(X0 - 1);
  localparam logic [10:0] BX_HI = 11'(X0 + GW * SCALE);
  localparam logic [10:0] BY_LO = 11'(Y0 - 1);
  localparam logic [10:0] BY_HI = 11'(Y0 + GH * SCALE);

  logic w_onBorder;
  logic r_borderD1;

  always_comb begin
    w_onBorder = de_in &&
      ((((r_hCnt == BX_LO) || (r_hCnt == BX_HI)) && (r_vCnt >= BY_LO) && (r_vCnt <= BY_HI)) ||
       (((r_vCnt == BY_LO) || (r_vCnt == BY_HI)) && (r_hCnt >= BX_LO) && (r_hCnt <= BX_HI)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_borderD1 <= 1'b0;
    else        r_borderD1 <= w_onBorder;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_inWinD1 <= 1'b0;
      r_deD1    <= 1'b0;
      r_hsD1    <= SYNC_IDLE;
      r_vsD1    <= SYNC_IDLE;
    end else begin
      r_addr    <= w_addrNext;
      r_inWinD1 <= w_inWin;
      r_deD1    <= de_in;
      r_hsD1    <= hs_in;
      r_vsD1    <= vs_in;
    end
  end

  // num answers the address registered in stage 1, so it lines up with the d1 flags here
  always_comb begin
    w_rgbNext = BG_COLOR;
    if (!r_deD1) begin
      w_rgbNext = '0;
    end else if (r_inWinD1) begin
      w_rgbNext = num ? FG_COLOR : BG_COLOR;
    end
`ifdef DIGIT_WIN_BORDER_EN
    else if (r_borderD1) begin
      w_rgbNext = FG_COLOR;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb   <= '0;
      r_deOut <= 1'b0;
      r_hsOut <= SYNC_IDLE;
      r_vsOut <= SYNC_IDLE;
    end else begin
      r_rgb   <= w_rgbNext;
      r_deOut <= r_deD1;
      r_hsOut <= r_hsD1;
      r_vsOut <= r_vsD1;
    end
  end

  assign addr   = r_addr;
  assign rgb    = r_rgb;
  assign de_out = r_deOut;
  assign hs_out = r_hsOut;
  assign vs_out = r_vsOut;

endmodule
